// File: rtl/wb_pkg.sv
// Shared widths and the write-back entry type for the register file write path.
package wb_pkg;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of write-back entries; push is ignored when full,
// pop is ignored when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PW'(1);
         if (do_pop)  rptr <= rptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= din;
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU results and buffered load responses into one registered register
// file write stream, and tracks outstanding loads for decode hazard stalls.
module regfile_write_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ld_issue,
   input  logic [REG_AW-1:0] ld_issue_rd,
   output logic              ld_issue_ready,
   input  logic              ld_resp_valid,
   input  logic [REG_AW-1:0] ld_resp_rd,
   input  logic [XLEN-1:0]   ld_resp_data,
   output logic              ld_resp_ready,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic [REG_AW-1:0] dec_rd,
   output logic              hazard,
   output logic [NREGS-1:0]  pending,
   output logic [REG_AW-1:0] RD,
   output logic [XLEN-1:0]   WriteData,
   output logic              RegWrite
);
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   wb_entry_t        fifo_din;
   wb_entry_t        fifo_dout;
   logic             wr_is_load;
   logic [NREGS-1:0] pending_nxt;

   assign ld_resp_ready  = !fifo_full;
   assign fifo_push      = ld_resp_valid && !fifo_full;
   assign fifo_pop       = !alu_valid && !fifo_empty;
   assign fifo_din       = '{rd: ld_resp_rd, data: ld_resp_data};
   assign ld_issue_ready = (ld_issue_rd == '0) || !pending[ld_issue_rd];
   assign hazard         = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A load clears its pending bit on the edge the register file captures it.
   always_comb begin
      pending_nxt = pending;
      if (ld_issue && ld_issue_ready && (ld_issue_rd != '0))
         pending_nxt[ld_issue_rd] = 1'b1;
      if (RegWrite && wr_is_load)
         pending_nxt[RD] = 1'b0;
      pending_nxt[0] = 1'b0;
   end

   // ALU always wins the write port; the FIFO head waits for an idle ALU cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         RD         <= '0;
         WriteData  <= '0;
         RegWrite   <= 1'b0;
         wr_is_load <= 1'b0;
         pending    <= '0;
      end else begin
         if (alu_valid) begin
            RD         <= alu_rd;
            WriteData  <= alu_data;
            RegWrite   <= (alu_rd != '0);
            wr_is_load <= 1'b0;
         end else if (!fifo_empty) begin
            RD         <= fifo_dout.rd;
            WriteData  <= fifo_dout.data;
            RegWrite   <= (fifo_dout.rd != '0);
            wr_is_load <= 1'b1;
         end else begin
            RegWrite   <= 1'b0;
            wr_is_load <= 1'b0;
         end
         pending <= pending_nxt;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus queues expected register file writes, a monitor
// pops and compares every presented write.
module tb_regfile_write_arbiter;
   import wb_pkg::*;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              alu_valid = 1'b0;
   logic [REG_AW-1:0] alu_rd = '0;
   logic [XLEN-1:0]   alu_data = '0;
   logic              ld_issue = 1'b0;
   logic [REG_AW-1:0] ld_issue_rd = '0;
   logic              ld_issue_ready;
   logic              ld_resp_valid = 1'b0;
   logic [REG_AW-1:0] ld_resp_rd = '0;
   logic [XLEN-1:0]   ld_resp_data = '0;
   logic              ld_resp_ready;
   logic [REG_AW-1:0] dec_rs1 = '0;
   logic [REG_AW-1:0] dec_rs2 = '0;
   logic [REG_AW-1:0] dec_rd = '0;
   logic              hazard;
   logic [NREGS-1:0]  pending;
   logic [REG_AW-1:0] RD;
   logic [XLEN-1:0]   WriteData;
   logic              RegWrite;

   int total = 0;
   int bad   = 0;
   wb_entry_t exp_q[$];

   regfile_write_arbiter #(.DEPTH(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .alu_valid      (alu_valid),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .ld_issue       (ld_issue),
      .ld_issue_rd    (ld_issue_rd),
      .ld_issue_ready (ld_issue_ready),
      .ld_resp_valid  (ld_resp_valid),
      .ld_resp_rd     (ld_resp_rd),
      .ld_resp_data   (ld_resp_data),
      .ld_resp_ready  (ld_resp_ready),
      .dec_rs1        (dec_rs1),
      .dec_rs2        (dec_rs2),
      .dec_rd         (dec_rd),
      .hazard         (hazard),
      .pending        (pending),
      .RD             (RD),
      .WriteData      (WriteData),
      .RegWrite       (RegWrite)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_wr(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
      exp_q.push_back('{rd: rd, data: data});
   endtask

   // Monitor: every presented write must match the head of the expected queue.
   always @(negedge clock) begin
      if (RegWrite) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", RD, WriteData);
         end else begin
            wb_entry_t e;
            e = exp_q.pop_front();
            check("wr_rd", 64'(RD), 64'(e.rd));
            check("wr_data", 64'(WriteData), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then idle
      step(); step();
      reset = 1'b0;
      step();
      check("rst_regwrite", 64'(RegWrite), 64'd0);
      check("rst_rd", 64'(RD), 64'd0);
      check("rst_wdata", 64'(WriteData), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_resp_ready", 64'(ld_resp_ready), 64'd1);

      // ALU write, then ALU write to x0
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      expect_wr(5'd5, 32'h1234);
      step();
      alu_valid = 1'b0;
      check("alu_latency_we", 64'(RegWrite), 64'd1);
      check("alu_latency_rd", 64'(RD), 64'd5);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      step();
      alu_valid = 1'b0;
      check("alu_x0_we", 64'(RegWrite), 64'd0);
      check("alu_x0_rd", 64'(RD), 64'd0);

      // Load scoreboard and hazards on rd 7
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      #1 check("issue7_ready", 64'(ld_issue_ready), 64'd1);
      step();
      ld_issue = 1'b0;
      check("pending7_set", 64'(pending), 64'h80);
      dec_rs1 = 5'd7;
      #1 check("hazard_rs1", 64'(hazard), 64'd1);
      dec_rs1 = 5'd0; dec_rd = 5'd7;
      #1 check("hazard_rd", 64'(hazard), 64'd1);
      dec_rd = 5'd0;
      #1 check("hazard_x0", 64'(hazard), 64'd0);
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      #1 check("issue7_blocked", 64'(ld_issue_ready), 64'd0);
      step();
      ld_issue = 1'b0;
      check("pending7_only", 64'(pending), 64'h80);
      ld_resp_valid = 1'b1; ld_resp_rd = 5'd7; ld_resp_data = 32'hCAFE;
      expect_wr(5'd7, 32'hCAFE);
      step();
      ld_resp_valid = 1'b0;
      check("ld_not_yet", 64'(RegWrite), 64'd0);
      step();
      check("ld_latency_we", 64'(RegWrite), 64'd1);
      check("ld_latency_rd", 64'(RD), 64'd7);
      check("pending7_held", 64'(pending[7]), 64'd1);
      step();
      check("pending7_clr", 64'(pending[7]), 64'd0);
      dec_rs2 = 5'd7;
      #1 check("hazard_clr", 64'(hazard), 64'd0);
      dec_rs2 = 5'd0;

      // Response arrives while ALU busy for 3 cycles
      ld_issue = 1'b1; ld_issue_rd = 5'd3;
      step();
      ld_issue = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h900;
      ld_resp_valid = 1'b1; ld_resp_rd = 5'd3; ld_resp_data = 32'hAA;
      expect_wr(5'd9, 32'h900);
      step();
      ld_resp_valid = 1'b0;
      alu_data = 32'h901; expect_wr(5'd9, 32'h901);
      step();
      alu_data = 32'h902; expect_wr(5'd9, 32'h902);
      step();
      alu_valid = 1'b0;
      expect_wr(5'd3, 32'hAA);
      step();
      check("stall_ld_rd", 64'(RD), 64'd3);
      step();
      check("pending3_clr", 64'(pending), 64'd0);

      // Fill FIFO behind a busy ALU, hold off a fifth response, drain in order
      for (int i = 1; i <= 5; i++) begin
         ld_issue = 1'b1; ld_issue_rd = (i == 5) ? 5'd11 : 5'(i);
         step();
      end
      ld_issue = 1'b0;
      check("pending_multi", 64'(pending), 64'h81E);
      alu_valid = 1'b1; alu_rd = 5'd10;
      for (int i = 1; i <= 4; i++) begin
         alu_data = 32'(32'hA00 + i);
         expect_wr(5'd10, alu_data);
         ld_resp_valid = 1'b1; ld_resp_rd = 5'(i); ld_resp_data = 32'(32'h100 + i);
         #1 check("fill_ready", 64'(ld_resp_ready), 64'd1);
         step();
      end
      ld_resp_rd = 5'd11; ld_resp_data = 32'h111;
      check("full_ready", 64'(ld_resp_ready), 64'd0);
      alu_data = 32'hA05; expect_wr(5'd10, 32'hA05);
      step();
      check("full_hold", 64'(ld_resp_ready), 64'd0);
      alu_valid = 1'b0;
      for (int i = 1; i <= 4; i++) expect_wr(5'(i), 32'(32'h100 + i));
      expect_wr(5'd11, 32'h111);
      for (int i = 0; i < 10 && !ld_resp_ready; i++) step();
      check("drain_ready", 64'(ld_resp_ready), 64'd1);
      step();
      ld_resp_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("drain_pending", 64'(pending), 64'd0);

      // Reset with two buffered loads discards them
      ld_issue = 1'b1; ld_issue_rd = 5'd6;
      step();
      ld_issue_rd = 5'd8;
      step();
      ld_issue = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd12;
      alu_data = 32'hC01; expect_wr(5'd12, 32'hC01);
      ld_resp_valid = 1'b1; ld_resp_rd = 5'd6; ld_resp_data = 32'h66;
      step();
      alu_data = 32'hC02; expect_wr(5'd12, 32'hC02);
      ld_resp_rd = 5'd8; ld_resp_data = 32'h88;
      step();
      ld_resp_valid = 1'b0;
      alu_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_pending", 64'(pending), 64'd0);
      check("mid_rst_we", 64'(RegWrite), 64'd0);
      check("mid_rst_ready", 64'(ld_resp_ready), 64'd1);
      ld_issue_rd = 5'd6;
      #1 check("mid_rst_issue6", 64'(ld_issue_ready), 64'd1);
      for (int i = 0; i < 6; i++) step();
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
